// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: holds the PC, fetches 32-bit words over a read/busywait
// handshake and issues decoded fields. Optional BNE redirect enabled by macro IFU_BNE_EN.
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RESET,
    output logic                IMEM_READ,
    output logic [PC_WIDTH-1:0] IMEM_ADDRESS,
    input  logic [31:0]         IMEM_READDATA,
    input  logic                IMEM_BUSYWAIT,
    input  logic                STALL,
    input  logic                BEQ_ENABLE,
    input  logic                JUMP_ENABLE,
`ifdef IFU_BNE_EN
    input  logic                BNE_ENABLE,
`endif
    input  logic                ZERO,
    output logic [7:0]          OPCODE,
    output logic [7:0]          RD_OFFSET,
    output logic [7:0]          RT,
    output logic [7:0]          RS_IMM,
    output logic                INSTR_VALID,
    output logic [PC_WIDTH-1:0] PC
);

    // state | meaning
    // FETCH | read request at PC outstanding; capture word when busywait is low
    // ISSUE | fields valid; advance PC when not stalled
    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic [31:0]         instr, instr_next;
    logic [PC_WIDTH-1:0] offset_words;
    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] pc_target;
    logic                redirect;
    logic                fetch_active;
    logic                issue_active;

    // Offset is a signed word count; scale to bytes and add to the sequential PC.
    assign offset_words = {{(PC_WIDTH-8){instr[23]}}, instr[23:16]};
    assign pc_seq       = pc + PC_WIDTH'(4);
    assign pc_target    = pc_seq + (offset_words << 2);

`ifdef IFU_BNE_EN
    assign redirect = JUMP_ENABLE | (BEQ_ENABLE & ZERO) | (BNE_ENABLE & ~ZERO);
`else
    assign redirect = JUMP_ENABLE | (BEQ_ENABLE & ZERO);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= FETCH;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            instr <= instr_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        instr_next   = instr;
        fetch_active = 1'b0;
        issue_active = 1'b0;
        case (state)
            FETCH: begin
                fetch_active = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    instr_next = IMEM_READDATA;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue_active = 1'b1;
                if (!STALL) begin
                    pc_next    = redirect ? pc_target : pc_seq;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Request is suppressed during the reset cycle so memory never sees a stale read.
    assign IMEM_READ    = fetch_active & ~RESET;
    assign IMEM_ADDRESS = pc;
    assign INSTR_VALID  = issue_active;
    assign PC           = pc;
    assign OPCODE       = instr[31:24];
    assign RD_OFFSET    = instr[23:16];
    assign RT           = instr[15:8];
    assign RS_IMM       = instr[7:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit: a driver predicts each issued
// (PC, word) pair from branch rules; a monitor pops and compares on every new issue.
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        STALL;
    logic        BEQ_ENABLE;
    logic        JUMP_ENABLE;
    logic        BNE_ENABLE;
    logic        ZERO;
    logic [7:0]  OPCODE;
    logic [7:0]  RD_OFFSET;
    logic [7:0]  RT;
    logic [7:0]  RS_IMM;
    logic        INSTR_VALID;
    logic [31:0] PC;

    instruction_fetch_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDRESS  (IMEM_ADDRESS),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .STALL         (STALL),
        .BEQ_ENABLE    (BEQ_ENABLE),
        .JUMP_ENABLE   (JUMP_ENABLE),
`ifdef IFU_BNE_EN
        .BNE_ENABLE    (BNE_ENABLE),
`endif
        .ZERO          (ZERO),
        .OPCODE        (OPCODE),
        .RD_OFFSET     (RD_OFFSET),
        .RT            (RT),
        .RS_IMM        (RS_IMM),
        .INSTR_VALID   (INSTR_VALID),
        .PC            (PC)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          tests = 0;
    int          fails = 0;
    int          issues = 0;
    bit          mon_en = 0;
    bit          prev_valid = 0;
    bit          v_issue = 0;
    bit          d_stall, d_jump, d_beq, d_bne, d_zero;
    logic [31:0] pc_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00040005;
        return (a * 32'h9E3779B1) ^ ((a >> 7) * 32'h85EBCA6B);
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input bit j, input bit b, input bit n, input bit z);
        logic signed [7:0] off;
        bit taken;
        off = ins[23:16];
        taken = j || (b && z) || (n && !z);
        if (taken) return pc + 32'd4 + 32'(int'(off) * 4);
        return pc + 32'd4;
    endfunction

    // Monitor: compares on each new issue, checks holds while stalled and the fetch address.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (INSTR_VALID && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("issue_unexpected", 32'(INSTR_VALID), 32'h0);
                end else begin
                    cur = exp_q.pop_front();
                    issues++;
                    chk("issue_pc", PC, cur.pc);
                    chk("issue_fields", {OPCODE, RD_OFFSET, RT, RS_IMM}, cur.instr);
                end
            end else if (INSTR_VALID) begin
                chk("hold_pc_fields", {PC ^ {OPCODE, RD_OFFSET, RT, RS_IMM}},
                    {cur.pc ^ cur.instr});
                chk("hold_no_read", 32'(IMEM_READ), 32'h0);
            end
            if (IMEM_READ) begin
                chk("fetch_not_valid", 32'(INSTR_VALID), 32'h0);
                if (exp_q.size() > 0) chk("fetch_addr", IMEM_ADDRESS, exp_q[0].pc);
            end
            prev_valid = INSTR_VALID;
        end
    end

    task automatic apply_reset();
        mon_en        = 0;
        RESET         = 1'b1;
        STALL         = 1'b0;
        BEQ_ENABLE    = 1'b0;
        JUMP_ENABLE   = 1'b0;
        BNE_ENABLE    = 1'b0;
        ZERO          = 1'b0;
        IMEM_BUSYWAIT = 1'b1;
        IMEM_READDATA = 32'hDEADBEEF;
        @(negedge CLK);
        chk("rst_cycle_no_read", 32'(IMEM_READ), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", 32'(INSTR_VALID), 32'h0);
        chk("rst_fields", {OPCODE, RD_OFFSET, RT, RS_IMM}, 32'h0);
        chk("rst_read_held_low", 32'(IMEM_READ), 32'h0);
        @(posedge CLK);
        #1;
        RESET         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        IMEM_READDATA = mem_word(IMEM_ADDRESS);
        v_issue       = 0;
        d_stall       = 0;
        pc_model      = 32'h0;
        exp_q.delete();
        exp_q.push_back('{pc: pc_model, instr: mem_word(pc_model)});
        prev_valid    = 0;
        mon_en        = 1;
    endtask

    task automatic run_random(input int ncycles);
        int last_issues;
        int idle;
        last_issues = issues;
        idle = 0;
        for (int c = 0; c < ncycles; c++) begin
            @(posedge CLK);
            if (v_issue && !d_stall) begin
                pc_model = model_next(pc_model, mem_word(pc_model), d_jump, d_beq, d_bne, d_zero);
                exp_q.push_back('{pc: pc_model, instr: mem_word(pc_model)});
            end
            #1;
            v_issue = INSTR_VALID;
            d_stall = ($urandom_range(0, 9) < 3);
            d_jump  = ($urandom_range(0, 19) < 3);
            d_beq   = ($urandom_range(0, 9) < 3);
            d_zero  = $urandom_range(0, 1) == 1;
`ifdef IFU_BNE_EN
            d_bne   = ($urandom_range(0, 9) < 3);
`else
            d_bne   = 0;
`endif
            STALL         = d_stall;
            JUMP_ENABLE   = d_jump;
            BEQ_ENABLE    = d_beq;
            ZERO          = d_zero;
            BNE_ENABLE    = d_bne;
            IMEM_BUSYWAIT = ($urandom_range(0, 9) < 4);
            IMEM_READDATA = mem_word(IMEM_ADDRESS);
            if (issues != last_issues) begin
                last_issues = issues;
                idle = 0;
            end else begin
                idle++;
                if (idle > 100) begin
                    chk("no_issue_within_100_cycles", 32'(idle), 32'h0);
                    break;
                end
            end
        end
    endtask

    initial begin
        bit reached;
        apply_reset();
        run_random(3000);

        // Park in FETCH with busywait high, then reset from there.
        mon_en = 0;
        @(posedge CLK);
        #1;
        STALL         = 1'b0;
        IMEM_BUSYWAIT = 1'b1;
        reached = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (IMEM_READ) begin
                reached = 1;
                break;
            end
        end
        chk("reach_fetch_before_reset", 32'(reached), 32'h1);
        apply_reset();
        run_random(1500);

        chk("enough_issues", 32'(issues >= 200), 32'h1);
        chk("leftover_expectations", 32'(exp_q.size() <= 1), 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
